// File: rtl/transpad_pkg.sv
// Shared types and widths for the transpad command path.
package transpad_pkg;
    localparam int UNIT_W  = 2;
    localparam int CMD_W   = 3;
    localparam int DATA_W  = 48;
    localparam int N_UNITS = 4;

    typedef struct packed {
        logic [UNIT_W-1:0] unit;
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] data;
    } transpad_cmd_t;
endpackage

// File: rtl/transpad_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so level spans 0..DEPTH.
module transpad_fifo
    import transpad_pkg::transpad_cmd_t;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  transpad_cmd_t            push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output transpad_cmd_t            head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    transpad_cmd_t mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (level_o == (AW+1)'(DEPTH));
    assign empty_o = (level_o == '0);
endmodule

// File: rtl/transpad_cmdq.sv
// Command queue + single-strobe issuer for the transpad array.
// Optional TRANSPAD_CMDQ_BYPASS_EN: push into an idle queue issues one cycle earlier.
module transpad_cmdq
    import transpad_pkg::transpad_cmd_t;
#(
    parameter int DEPTH  = 8,
    parameter int UNIT_W = 2,
    parameter int CMD_W  = 3,
    parameter int DATA_W = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [UNIT_W-1:0]        in_unit,
    input  logic [CMD_W-1:0]         in_cmd,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     hold,
    input  logic                     flush,
    output logic [UNIT_W-1:0]        unit,
    output logic                     rdy,
    output logic [CMD_W-1:0]         cmd,
    output logic [DATA_W-1:0]        data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty
);
    transpad_cmd_t in_entry, head, out_q, out_d;
    logic          rdy_q, rdy_d;
    logic          fifo_full, fifo_empty;
    logic          push, pop, bypass;

    assign in_entry.unit = in_unit;
    assign in_entry.cmd  = in_cmd;
    assign in_entry.data = in_data;

    assign in_ready = ~fifo_full & ~rst & ~flush;
    assign push     = in_valid & in_ready;
    assign pop      = ~fifo_empty & ~hold & ~flush;

`ifdef TRANSPAD_CMDQ_BYPASS_EN
    // Only an idle queue may be bypassed, so strobe order matches the FIFO path.
    assign bypass = push & fifo_empty & ~hold;
`else
    assign bypass = 1'b0;
`endif

    transpad_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push & ~bypass),
        .push_data_i (in_entry),
        .pop_i       (pop),
        .flush_i     (flush),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (level)
    );

    always_comb begin
        out_d = out_q;
        rdy_d = 1'b0;
        if (pop) begin
            out_d = head;
            rdy_d = 1'b1;
        end else if (bypass) begin
            out_d = in_entry;
            rdy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            rdy_q <= 1'b0;
        end else begin
            out_q <= out_d;
            rdy_q <= rdy_d;
        end
    end

    assign unit  = out_q.unit;
    assign cmd   = out_q.cmd;
    assign data  = out_q.data;
    assign rdy   = rdy_q;
    assign empty = fifo_empty;
endmodule

// File: tb/tb_transpad_cmdq.sv
// Directed self-checking bench for transpad_cmdq (both bypass variants).
module tb_transpad_cmdq;
`ifdef TRANSPAD_CMDQ_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk, rst, in_valid, in_ready, hold, flush, rdy, empty;
    logic [1:0]  in_unit, unit;
    logic [2:0]  in_cmd, cmd;
    logic [47:0] in_data, data;
    logic [3:0]  level;
    int          n_cmp, n_bad;

    transpad_cmdq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_unit(in_unit), .in_cmd(in_cmd), .in_data(in_data),
        .hold(hold), .flush(flush), .unit(unit), .rdy(rdy), .cmd(cmd),
        .data(data), .level(level), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int u, input int c, input int d);
        in_valid = v;
        in_unit  = u[1:0];
        in_cmd   = c[2:0];
        in_data  = 48'(d);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp += 6;
        if (rdy !== 1'b0)   begin n_bad++; $display("FAIL reset_rdy: got %0h want 0", rdy); end
        if ({unit, cmd} !== 5'd0) begin n_bad++; $display("FAIL reset_unit_cmd: got %0h want 0", {unit, cmd}); end
        if (data !== 48'd0) begin n_bad++; $display("FAIL reset_data: got %0h want 0", data); end
        if (level !== 4'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", level); end
        if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %0h want 1", empty); end
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %0h want 0", in_ready); end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready: got %0h want 1", in_ready); end
    endtask

    task automatic test_latency();
        drive(1'b1, 2, 1, 'h1234);
        step();
        drive(1'b0, 0, 0, 0);
`ifndef TRANSPAD_CMDQ_BYPASS_EN
        n_cmp += 2;
        if (rdy !== 1'b0)   begin n_bad++; $display("FAIL lat_early_rdy: got %0h want 0", rdy); end
        if (level !== 4'd1) begin n_bad++; $display("FAIL lat_level: got %0d want 1", level); end
        step();
`endif
        n_cmp += 3;
        if (rdy !== 1'b1) begin n_bad++; $display("FAIL lat_rdy: got %0h want 1", rdy); end
        if ({unit, cmd} !== {2'd2, 3'd1}) begin n_bad++; $display("FAIL lat_unit_cmd: got %0h want %0h", {unit, cmd}, {2'd2, 3'd1}); end
        if (data !== 48'h1234) begin n_bad++; $display("FAIL lat_data: got %0h want 1234", data); end
        step();
        n_cmp += 4;
        if (rdy !== 1'b0) begin n_bad++; $display("FAIL lat_rdy_drop: got %0h want 0", rdy); end
        if ({unit, cmd} !== {2'd2, 3'd1} || data !== 48'h1234) begin n_bad++; $display("FAIL lat_hold_fields: got %0h/%0h want 11/1234", {unit, cmd}, data); end
        if (level !== 4'd0) begin n_bad++; $display("FAIL lat_level_end: got %0d want 0", level); end
        if (empty !== 1'b1) begin n_bad++; $display("FAIL lat_empty_end: got %0h want 1", empty); end
    endtask

    task automatic test_full();
        hold = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i % 4, i % 8, 100 + i);
            step();
        end
        n_cmp += 2;
        if (level !== 4'd8)    begin n_bad++; $display("FAIL full_level: got %0d want 8", level); end
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_in_ready: got %0h want 0", in_ready); end
        drive(1'b1, 3, 7, 999);
        step();
        drive(1'b0, 0, 0, 0);
        n_cmp++;
        if (level !== 4'd8) begin n_bad++; $display("FAIL full_ninth_push: level got %0d want 8", level); end
        hold = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if (rdy !== 1'b1 || data !== 48'(100 + i) || unit !== 2'(i % 4) || cmd !== 3'(i % 8)) begin
                n_bad++;
                $display("FAIL full_drain_%0d: got rdy=%0h data=%0d unit=%0d cmd=%0d want rdy=1 data=%0d unit=%0d cmd=%0d",
                         i, rdy, data, unit, cmd, 100 + i, i % 4, i % 8);
            end
        end
        n_cmp += 2;
        if (level !== 4'd0) begin n_bad++; $display("FAIL full_level_end: got %0d want 0", level); end
        if (empty !== 1'b1) begin n_bad++; $display("FAIL full_empty_end: got %0h want 1", empty); end
        step();
        n_cmp++;
        if (rdy !== 1'b0 || data !== 48'd107) begin n_bad++; $display("FAIL full_after: got rdy=%0h data=%0d want rdy=0 data=107", rdy, data); end
    endtask

    task automatic test_hold_toggle();
        int  nxt;
        logic exp_pop;
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (i + 1) % 4, i, 200 + i);
            step();
        end
        drive(1'b0, 0, 0, 0);
        nxt = 0;
        for (int c = 0; c < 8; c++) begin
            hold = (c % 2 == 1);
            exp_pop = !hold && (nxt < 4);
            step();
            n_cmp++;
            if (rdy !== exp_pop) begin
                n_bad++;
                $display("FAIL toggle_rdy_c%0d: got %0h want %0h", c, rdy, exp_pop);
            end else if (exp_pop && (data !== 48'(200 + nxt) || unit !== 2'((nxt + 1) % 4))) begin
                n_bad++;
                $display("FAIL toggle_order_c%0d: got data=%0d unit=%0d want data=%0d unit=%0d", c, data, unit, 200 + nxt, (nxt + 1) % 4);
            end
            if (exp_pop) nxt++;
        end
        n_cmp++;
        if (level !== 4'd0) begin n_bad++; $display("FAIL toggle_level: got %0d want 0", level); end
        hold = 1'b0;
    endtask

    task automatic test_flush();
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 0, 2, 300 + i);
            step();
        end
        drive(1'b1, 1, 1, 399);
        flush = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready: got %0h want 0", in_ready); end
        step();
        flush = 1'b0;
        hold  = 1'b0;
        drive(1'b0, 0, 0, 0);
        n_cmp += 3;
        if (level !== 4'd0) begin n_bad++; $display("FAIL flush_level: got %0d want 0", level); end
        if (rdy !== 1'b0)   begin n_bad++; $display("FAIL flush_rdy: got %0h want 0", rdy); end
        if (empty !== 1'b1) begin n_bad++; $display("FAIL flush_empty: got %0h want 1", empty); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (rdy !== 1'b0) begin n_bad++; $display("FAIL flush_quiet_%0d: got rdy=%0h want 0", i, rdy); end
        end
        drive(1'b1, 3, 5, 400);
        step();
        drive(1'b0, 0, 0, 0);
        for (int i = 1; i < LAT; i++) step();
        n_cmp++;
        if (rdy !== 1'b1 || data !== 48'd400 || unit !== 2'd3 || cmd !== 3'd5) begin
            n_bad++;
            $display("FAIL flush_next_push: got rdy=%0h data=%0d unit=%0d cmd=%0d want 1/400/3/5", rdy, data, unit, cmd);
        end
        step();
    endtask

    task automatic test_rst_mid();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1, 6, 500 + i);
            step();
        end
        drive(1'b0, 0, 0, 0);
        hold = 1'b0;
        step();
        n_cmp++;
        if (rdy !== 1'b1 || data !== 48'd500) begin n_bad++; $display("FAIL rstmid_first: got rdy=%0h data=%0d want 1/500", rdy, data); end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_in_ready: got %0h want 0", in_ready); end
        step();
        rst = 1'b0;
        n_cmp += 3;
        if ({rdy, unit, cmd} !== 6'd0 || data !== 48'd0) begin n_bad++; $display("FAIL rstmid_outputs: got %0h/%0h want 0/0", {rdy, unit, cmd}, data); end
        if (level !== 4'd0) begin n_bad++; $display("FAIL rstmid_level: got %0d want 0", level); end
        if (empty !== 1'b1) begin n_bad++; $display("FAIL rstmid_empty: got %0h want 1", empty); end
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (rdy !== 1'b0 || level !== 4'd0) begin n_bad++; $display("FAIL rstmid_quiet_%0d: got rdy=%0h level=%0d want 0/0", i, rdy, level); end
        end
    endtask

    task automatic test_back_to_back();
        int k;
        hold = 1'b0;
        for (int c = 0; c < 4 + LAT; c++) begin
            if (c < 4) drive(1'b1, c, c, 600 + c);
            else       drive(1'b0, 0, 0, 0);
            step();
            k = c - (LAT - 1);
            n_cmp++;
            if (k >= 0 && k < 4) begin
                if (rdy !== 1'b1 || data !== 48'(600 + k) || unit !== 2'(k)) begin
                    n_bad++;
                    $display("FAIL b2b_c%0d: got rdy=%0h data=%0d unit=%0d want 1/%0d/%0d", c, rdy, data, unit, 600 + k, k);
                end
            end else if (rdy !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b_idle_c%0d: got rdy=%0h want 0", c, rdy);
            end
        end
        drive(1'b0, 0, 0, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        hold = 1'b0;
        flush = 1'b0;
        drive(1'b0, 0, 0, 0);
        test_reset();
        test_latency();
        test_full();
        test_hold_toggle();
        test_flush();
        test_rst_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
